// File: rtl/trade_order_arbiter.sv
// -----------------------------------------------------------------------------
// trade_order_arbiter
//
// Shares one downstream order port between N_REQ arbitrage checker cores.
// Pending requests are granted round-robin. The granted price is captured and
// presented downstream with a valid/ready handshake. The block also enforces
// a minimum idle gap after each accepted order, a limit on open (accepted but
// unfilled) orders, and a kill switch.
//
// Ports:
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous, active-high reset
//   req_valid  : per-requester trade request, held until its req_ready
//   req_price  : per-requester price, lane i at [i*PRICE_W +: PRICE_W]
//   req_ready  : one-hot grant/capture strobe (combinational)
//   ord_valid  : order presented downstream
//   ord_ready  : downstream accepts when ord_valid && ord_ready
//   ord_price  : captured price of the granted requester
//   ord_src    : index of the granted requester
//   fill_ack   : one pulse per filled order, returns one credit
//   kill       : level, blocks new grants while high
//   open_cnt   : current number of outstanding orders
//   throttled  : request pending in IDLE but blocked (kill or no credit)
// -----------------------------------------------------------------------------
module trade_order_arbiter #(
    parameter int N_REQ    = 4,
    parameter int PRICE_W  = 64,
    parameter int MIN_GAP  = 4,
    parameter int MAX_OPEN = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*PRICE_W-1:0]   req_price,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       ord_valid,
    input  logic                       ord_ready,
    output logic [PRICE_W-1:0]         ord_price,
    output logic [$clog2(N_REQ)-1:0]   ord_src,
    input  logic                       fill_ack,
    input  logic                       kill,
    output logic [7:0]                 open_cnt,
    output logic                       throttled
);

    localparam int SRC_W = $clog2(N_REQ);
    localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);
    localparam logic [7:0]       OPEN_MAX = 8'(MAX_OPEN);
    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SRC_W-1:0]   rr_ptr;
    logic [GAP_W-1:0]   gap_cnt;
    logic [SRC_W-1:0]   grant_idx;
    logic               grant_found;
    logic               eligible;
    logic               accept;
    logic               do_grant;

    // Round-robin search: first set request at or above rr_ptr, with wrap.
    always_comb begin
        int               idx;
        logic [SRC_W-1:0] idx_s;
        idx         = 0;
        idx_s       = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_s = SRC_W'(idx);
            if (!grant_found && req_valid[idx_s]) begin
                grant_found = 1'b1;
                grant_idx   = idx_s;
            end
        end
    end

    assign eligible  = grant_found && !kill && (open_cnt < OPEN_MAX);
    assign ord_valid = (state == ISSUE);
    assign accept    = ord_valid && ord_ready;
    assign do_grant  = (state == IDLE) && eligible && !rst;

    // Next-state and strobes. Grant/throttle strobes are masked during reset
    // so requesters never see a capture that the register update discards.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        throttled = 1'b0;
        case (state)
            IDLE: begin
                if (eligible) begin
                    req_ready[grant_idx] = 1'b1;
                    state_nxt            = ISSUE;
                end else begin
                    throttled = |req_valid;
                end
            end
            ISSUE: begin
                // kill is deliberately ignored here: a presented order is
                // never retracted.
                if (accept) begin
                    state_nxt = (MIN_GAP > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            req_ready = '0;
            throttled = 1'b0;
        end
    end

    // Control state: FSM, round-robin pointer, gap timer, credit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gap_cnt  <= '0;
            open_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (do_grant) begin
                rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end
            if (accept) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            // Accept and fill in the same cycle cancel out; a fill with no
            // open order is ignored.
            if (accept && !fill_ack) begin
                open_cnt <= open_cnt + 1'b1;
            end else if (fill_ack && !accept && (open_cnt != 8'd0)) begin
                open_cnt <= open_cnt - 1'b1;
            end
        end
    end

    // Order capture: price and source latched on the grant edge, held
    // unchanged until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ord_price <= '0;
            ord_src   <= '0;
        end else if (do_grant) begin
            ord_price <= req_price[grant_idx*PRICE_W +: PRICE_W];
            ord_src   <= grant_idx;
        end
    end

endmodule
